fetch_buffer: RTL and testbench

Parametrised fetch buffer between the fetch unit and decode. It decouples the two stages with a DEPTH-entry queue of I-cache lines and splits each line into up to FETCH_WIDTH instructions per cycle. Beyond the single-line stall/valid/fault/flush hand-off, it adds:
- ready/valid flow control on both sides;
- a mid-line start offset for redirect targets;
- per-line fault propagation;
- configurable depth and issue width.

---
 rtl/fetch_buffer_pkg.sv | 25 ++
 rtl/fetch_buffer_ram.sv | 33 +++
 rtl/fetch_buffer.sv | 164 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch buffer: cache line type, entry layout, insn width and sizing helpers.
package CacheTypes;
    localparam int unsigned ICACHE_LINE_WIDTH = 128;
    typedef logic [ICACHE_LINE_WIDTH-1:0] icache_line_t;
endpackage

package FetchBufferTypes;
    import CacheTypes::*;

    localparam int unsigned INSN_WIDTH = 32;

    typedef struct packed {
        logic [31:0]  pc;
        icache_line_t line;
        logic         fault;
    } fetch_buffer_entry_t;

    function automatic int unsigned words_of(input int unsigned line_width);
        return line_width / INSN_WIDTH;
    endfunction

    function automatic int unsigned off_bits(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction
endpackage

// File: rtl/fetch_buffer_ram.sv
// DEPTH-entry line storage: one synchronous write port, one combinational read port, no reset.
module fetch_buffer_ram #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned VADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [VADDR_WIDTH-1:0]   wpc,
    input  logic [LINE_WIDTH-1:0]    wline,
    input  logic                     wfault,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [VADDR_WIDTH-1:0]   rpc,
    output logic [LINE_WIDTH-1:0]    rline,
    output logic                     rfault
);
    logic [VADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [LINE_WIDTH-1:0]  line_mem  [DEPTH];
    logic                   fault_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem[waddr]    <= wpc;
            line_mem[waddr]  <= wline;
            fault_mem[waddr] <= wfault;
        end
    end

    assign rpc    = pc_mem[raddr];
    assign rline  = line_mem[raddr];
    assign rfault = fault_mem[raddr];
endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: queues I-cache lines and issues up to FETCH_WIDTH instructions per cycle.
// Optional FETCH_BUFFER_BYPASS_EN adds a same-cycle in-to-out path when the buffer is empty.
module fetch_buffer
    import FetchBufferTypes::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned VADDR_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               inValid,
    output logic                               inReady,
    input  logic [VADDR_WIDTH-1:0]             inPc,
    input  logic [LINE_WIDTH-1:0]              inLine,
    input  logic                               inFault,
    output logic [FETCH_WIDTH-1:0]             outValid,
    output logic [FETCH_WIDTH*VADDR_WIDTH-1:0] outPc,
    output logic [FETCH_WIDTH*INSN_WIDTH-1:0]  outInsn,
    output logic                               outFault,
    input  logic                               outReady,
    input  logic                               flush,
    output logic [$clog2(DEPTH):0]             count
);
    localparam int unsigned WORDS = words_of(LINE_WIDTH);
    localparam int unsigned OW    = off_bits(WORDS);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam logic [OW:0] WORDS_W = (OW + 1)'(WORDS);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic [OW-1:0] offset;
    logic          fresh;

    logic [VADDR_WIDTH-1:0] rpc;
    logic [LINE_WIDTH-1:0]  rline;
    logic                   rfault;

    logic                   empty, bypass, have;
    logic [VADDR_WIDTH-1:0] src_pc;
    logic [LINE_WIDTH-1:0]  src_line;
    logic                   src_fault;
    logic [OW-1:0]          cur_off;
    logic [OW:0]            idx, nvalid, adv;
    logic                   push, pop, line_done, do_write, ram_pop;

    fetch_buffer_ram #(
        .DEPTH      (DEPTH),
        .LINE_WIDTH (LINE_WIDTH),
        .VADDR_WIDTH(VADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (tail),
        .wpc   (inPc),
        .wline (inLine),
        .wfault(inFault),
        .raddr (head),
        .rpc   (rpc),
        .rline (rline),
        .rfault(rfault)
    );

    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign inReady = (cnt < CW'(DEPTH));

    // A new head takes its offset from its own pc; 'fresh' selects that instead of a
    // separate load, so no second read port is needed to peek at the next entry.
`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = empty && inValid && !flush;
    always_comb begin
        src_pc    = bypass ? inPc    : rpc;
        src_line  = bypass ? inLine  : rline;
        src_fault = bypass ? inFault : rfault;
        cur_off   = bypass ? inPc[OW+1:2] : (fresh ? rpc[OW+1:2] : offset);
    end
`else
    assign bypass = 1'b0;
    always_comb begin
        src_pc    = rpc;
        src_line  = rline;
        src_fault = rfault;
        cur_off   = fresh ? rpc[OW+1:2] : offset;
    end
`endif

    assign have = bypass || !empty;

    always_comb begin
        outValid = '0;
        outPc    = '0;
        outInsn  = '0;
        outFault = 1'b0;
        nvalid   = '0;
        idx      = '0;
        if (have && src_fault) begin
            outValid[0]                 = 1'b1;
            outFault                    = 1'b1;
            outPc[VADDR_WIDTH-1:0]      = src_pc;
            nvalid                      = (OW + 1)'(1);
        end else if (have) begin
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                idx = {1'b0, cur_off} + (OW + 1)'(i);
                if (idx < WORDS_W) begin
                    outValid[i] = 1'b1;
                    outPc[i*VADDR_WIDTH +: VADDR_WIDTH] =
                        {src_pc[VADDR_WIDTH-1:OW+2], idx[OW-1:0], 2'b00};
                    outInsn[i*INSN_WIDTH +: INSN_WIDTH] =
                        src_line[INSN_WIDTH*int'(idx[OW-1:0]) +: INSN_WIDTH];
                    nvalid = nvalid + (OW + 1)'(1);
                end
            end
        end
    end

    assign adv       = {1'b0, cur_off} + nvalid;
    assign pop       = outReady && outValid[0] && !flush;
    assign line_done = pop && (src_fault || adv == WORDS_W);
    assign push      = inValid && inReady && !flush;
    assign do_write  = push && !(bypass && line_done);
    assign ram_pop   = line_done && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            offset <= '0;
            fresh  <= 1'b0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            offset <= '0;
            fresh  <= 1'b0;
        end else begin
            if (do_write) tail <= tail + PW'(1);
            if (ram_pop)  head <= head + PW'(1);
            case ({do_write, ram_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (empty) begin
                if (do_write) begin
                    if (pop) begin
                        offset <= adv[OW-1:0];
                        fresh  <= 1'b0;
                    end else begin
                        fresh  <= 1'b1;
                    end
                end
            end else if (ram_pop) begin
                fresh <= 1'b1;
            end else if (pop) begin
                offset <= adv[OW-1:0];
                fresh  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed bench for fetch_buffer against a queue-of-lines reference model.
module tb_fetch_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic         inValid, inReady, inFault, outFault, outReady, flush;
    logic [31:0]  inPc;
    logic [127:0] inLine;
    logic [1:0]   outValid;
    logic [63:0]  outPc, outInsn;
    logic [2:0]   count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] line;
        bit           fault;
        int unsigned  off;
    } ent_t;
    ent_t q[$];

    fetch_buffer #(
        .DEPTH      (4),
        .LINE_WIDTH (128),
        .FETCH_WIDTH(2),
        .VADDR_WIDTH(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inValid (inValid),
        .inReady (inReady),
        .inPc    (inPc),
        .inLine  (inLine),
        .inFault (inFault),
        .outValid(outValid),
        .outPc   (outPc),
        .outInsn (outInsn),
        .outFault(outFault),
        .outReady(outReady),
        .flush   (flush),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    // Compares outputs with the model, then advances one clock and updates the model.
    task automatic step(input bit v, input logic [31:0] pc, input logic [127:0] ln,
                        input bit f, input bit rdy, input bit fl);
        logic [1:0]  ev;
        int unsigned n, w;
        bit          rdy_exp;
        inValid  = v;
        inPc     = pc;
        inLine   = ln;
        inFault  = f;
        outReady = rdy;
        flush    = fl;
        #1;
        rdy_exp = (q.size() < 4);
        check("inReady", 64'(inReady), 64'(rdy_exp));
        check("count", 64'(count), 64'(q.size()));
        ev = 2'b00;
        n  = 0;
        if (q.size() > 0) begin
            if (q[0].fault) begin
                ev = 2'b01;
                n  = 1;
                check("pc0_fault", 64'(outPc[31:0]), 64'(q[0].pc));
                check("insn0_fault", 64'(outInsn[31:0]), 64'd0);
            end else begin
                for (int unsigned i = 0; i < 2; i++) begin
                    w = q[0].off + i;
                    if (w < 4) begin
                        ev[i] = 1'b1;
                        n++;
                        check($sformatf("pc%0d", i), 64'(outPc[i*32 +: 32]),
                              64'({q[0].pc[31:4], 4'b0} + 32'(w * 4)));
                        check($sformatf("insn%0d", i), 64'(outInsn[i*32 +: 32]),
                              64'(q[0].line[w*32 +: 32]));
                    end
                end
            end
        end
        check("outValid", 64'(outValid), 64'(ev));
        check("outFault", 64'(outFault), 64'((q.size() > 0) && q[0].fault));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (rdy && q.size() > 0) begin
                if (q[0].fault) begin
                    void'(q.pop_front());
                end else begin
                    q[0].off += n;
                    if (q[0].off >= 4) void'(q.pop_front());
                end
            end
            if (v && rdy_exp) q.push_back('{pc, ln, f, int'(pc[3:2])});
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'h0, 128'h0, 1'b0, rdy, 1'b0);
    endtask

    function automatic logic [127:0] rline();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [127:0] ABCD = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    initial begin
        rst = 1'b1; inValid = 0; inPc = '0; inLine = '0; inFault = 0; outReady = 0; flush = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);

        // basic drain
        step(1'b1, 32'h1000, ABCD, 1'b0, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        // mid-line redirect
        step(1'b1, 32'h100C, ABCD, 1'b0, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);
        // fault
        step(1'b1, 32'h2000, rline(), 1'b1, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);
        // full, one pop, wrap on 5th push
        for (int unsigned i = 0; i < 4; i++)
            step(1'b1, 32'h4008 + 32'(i * 16), rline(), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h5000, rline(), 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h5010, rline(), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int unsigned i = 0; i < 10; i++) idle(1'b1);
        // flush with simultaneous push
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, 32'h6000 + 32'(i * 16), rline(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7000, rline(), 1'b0, 1'b0, 1'b1);
        idle(1'b1); idle(1'b1);
        // reset mid-drain
        step(1'b1, 32'h8000, rline(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h8010, rline(), 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_inReady", 64'(inReady), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h3000, rline(), 1'b0, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // randomized traffic
        for (int unsigned c = 0; c < 2000; c++) begin
            step(($urandom % 4) != 0, $urandom() & 32'hFFFF_FFFC, rline(),
                 ($urandom % 8) == 0, ($urandom % 3) != 0, ($urandom % 32) == 0);
        end
        for (int unsigned i = 0; i < 12; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
